// File: rtl/clint_axi_slave_pkg.sv
// rtl/clint_axi_slave_pkg.sv - CLINT register map, AXI response codes and FSM state encodings
package clint_axi_slave_pkg;
    localparam logic [31:0] CLINT_L    = 32'h0200_BFF8;
    localparam logic [31:0] CLINT_H    = 32'h0200_BFFC;
    localparam logic [31:0] MTIMECMP_L = 32'h0200_4000;
    localparam logic [31:0] MTIMECMP_H = 32'h0200_4004;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // A 32-bit register word rides on the 64-bit bus lane selected by addr[2].
    function automatic logic [63:0] place_lane(input logic [31:0] word, input logic hi);
        return hi ? {word, 32'h0} : {32'h0, word};
    endfunction
endpackage

// File: rtl/clint_mtime_counter.sv
// rtl/clint_mtime_counter.sv - divided free-running 64-bit mtime, plus mtimecmp/mtip under CLINT_MTIMECMP_EN
module clint_mtime_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
`ifdef CLINT_MTIMECMP_EN
    input  logic        cmp_we_i,
    input  logic        cmp_hi_i,
    input  logic [31:0] cmp_wdata_i,
    input  logic [3:0]  cmp_wstrb_i,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o,
`endif
    output logic [63:0] mtime_o
);
    logic [31:0] div_q, div_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = (div_q == TICK_DIV - 1);
        div_d   = tick ? 32'd0 : div_q + 32'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            div_q   <= '0;
            mtime_q <= '0;
        end else begin
            div_q   <= div_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

`ifdef CLINT_MTIMECMP_EN
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q;

    always_comb begin
        cmp_d = cmp_q;
        if (cmp_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (cmp_wstrb_i[i]) begin
                    if (cmp_hi_i) cmp_d[32 + 8*i +: 8] = cmp_wdata_i[8*i +: 8];
                    else          cmp_d[8*i +: 8]      = cmp_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cmp_q  <= '1;
            mtip_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            mtip_q <= (mtime_q >= cmp_q);
        end
    end

    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;
`endif
endmodule

// File: rtl/clint_axi_slave.sv
// rtl/clint_axi_slave.sv - AXI4-style CLINT responder (mtime, optional mtimecmp/mtip via CLINT_MTIMECMP_EN)
module clint_axi_slave
    import clint_axi_slave_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         araddr,
    input  logic                arvalid,
    input  logic [3:0]          arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                arready,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic [1:0]          rresp,
    output logic [3:0]          rid,
    output logic                rlast,
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    input  logic [3:0]          awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    input  logic                wlast,
    output logic                wready,
    input  logic                bready,
    output logic                bvalid,
    output logic [1:0]          bresp
`ifdef CLINT_MTIMECMP_EN
    ,
    output logic                mtip
`endif
);
    logic [63:0] mtime;

`ifdef CLINT_MTIMECMP_EN
    logic [63:0] mtimecmp;
    logic        mtip_raw;
    logic        cmp_we;
    logic        wr_cmp_q, wr_cmp_d;
    logic        wr_hi_q, wr_hi_d;
    logic        unused_ok;

    assign unused_ok = ^{awid, awsize, awburst, arsize, arburst};

    clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
        .clock_i     (clock),
        .reset_i     (reset),
        .cmp_we_i    (cmp_we),
        .cmp_hi_i    (wr_hi_q),
        .cmp_wdata_i (wr_hi_q ? wdata[63:32] : wdata[31:0]),
        .cmp_wstrb_i (wr_hi_q ? wstrb[7:4] : wstrb[3:0]),
        .mtimecmp_o  (mtimecmp),
        .mtip_o      (mtip_raw),
        .mtime_o     (mtime)
    );
    assign mtip = mtip_raw && !reset;
`else
    logic unused_ok;

    assign unused_ok = ^{awaddr, awid, awsize, awburst, arsize, arburst, wdata, wstrb,
                         MTIMECMP_L, MTIMECMP_H};

    clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
        .clock_i (clock),
        .reset_i (reset),
        .mtime_o (mtime)
    );
`endif

    r_state_e    r_state_q, r_state_d;
    logic [31:0] lat_q, lat_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [3:0]  rid_q, rid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rd_word;
    logic        rd_hit;

    always_comb begin
        rd_hit  = 1'b1;
        rd_word = '0;
        case (araddr)
            CLINT_L:    rd_word = mtime[31:0];
            CLINT_H:    rd_word = mtime[63:32];
`ifdef CLINT_MTIMECMP_EN
            MTIMECMP_L: rd_word = mtimecmp[31:0];
            MTIMECMP_H: rd_word = mtimecmp[63:32];
`endif
            default:    rd_hit  = 1'b0;
        endcase
    end

    // Beat data and response are fixed at AR capture, so they stay stable through R stalls.
    always_comb begin
        r_state_d = r_state_q;
        lat_d     = lat_q;
        rcnt_d    = rcnt_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d  = arid;
                    rcnt_d = arlen;
                    lat_d  = '0;
                    if (arlen != 8'd0) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                    end else if (rd_hit) begin
                        rresp_d = RESP_OKAY;
                        rdata_d = place_lane(rd_word, araddr[2]);
                    end else begin
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                    end
                    r_state_d = (READ_LAT == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                lat_d = lat_q + 32'd1;
                if (lat_q + 32'd1 >= READ_LAT) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    if (rcnt_q == 8'd0) r_state_d = R_IDLE;
                    else                rcnt_d    = rcnt_q - 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            lat_q     <= '0;
            rcnt_q    <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            lat_q     <= lat_d;
            rcnt_q    <= rcnt_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = (r_state_q == R_IDLE) && !reset;
    assign rvalid  = (r_state_q == R_DATA) && !reset;
    assign rdata   = rvalid ? rdata_q : '0;
    assign rresp   = rvalid ? rresp_q : RESP_OKAY;
    assign rid     = rvalid ? rid_q : '0;
    assign rlast   = rvalid && (rcnt_q == 8'd0);

    w_state_e   w_state_q, w_state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [1:0] bresp_q, bresp_d;

    always_comb begin
        w_state_d = w_state_q;
        wcnt_d    = wcnt_q;
        bresp_d   = bresp_q;
`ifdef CLINT_MTIMECMP_EN
        wr_cmp_d  = wr_cmp_q;
        wr_hi_d   = wr_hi_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    wcnt_d  = awlen;
                    bresp_d = RESP_SLVERR;
`ifdef CLINT_MTIMECMP_EN
                    // Only a single-beat write to a mtimecmp half is honoured.
                    wr_cmp_d = (awlen == 8'd0) && (awaddr == MTIMECMP_L || awaddr == MTIMECMP_H);
                    wr_hi_d  = awaddr[2];
                    if (wr_cmp_d) bresp_d = RESP_OKAY;
`endif
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    if (wlast || wcnt_q == 8'd0) w_state_d = W_RESP;
                    else                         wcnt_d    = wcnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            wcnt_q    <= '0;
            bresp_q   <= RESP_OKAY;
`ifdef CLINT_MTIMECMP_EN
            wr_cmp_q  <= 1'b0;
            wr_hi_q   <= 1'b0;
`endif
        end else begin
            w_state_q <= w_state_d;
            wcnt_q    <= wcnt_d;
            bresp_q   <= bresp_d;
`ifdef CLINT_MTIMECMP_EN
            wr_cmp_q  <= wr_cmp_d;
            wr_hi_q   <= wr_hi_d;
`endif
        end
    end

`ifdef CLINT_MTIMECMP_EN
    assign cmp_we = (w_state_q == W_DATA) && wvalid && wr_cmp_q && !reset;
`endif

    assign awready = (w_state_q == W_IDLE) && !reset;
    assign wready  = (w_state_q == W_DATA) && !reset;
    assign bvalid  = (w_state_q == W_RESP) && !reset;
    assign bresp   = bvalid ? bresp_q : RESP_OKAY;
endmodule

// File: tb/tb_clint_axi_slave.sv
// tb/tb_clint_axi_slave.sv - directed plus randomized bench for clint_axi_slave against a timeline model of mtime
module tb_clint_axi_slave;
    localparam int unsigned TICK_DIV = 1;
    localparam int unsigned READ_LAT = 1;
    localparam logic [31:0] A_TIME_L = 32'h0200_BFF8;
    localparam logic [31:0] A_TIME_H = 32'h0200_BFFC;
    localparam logic [31:0] A_CMP_L  = 32'h0200_4000;
    localparam logic [31:0] A_CMP_H  = 32'h0200_4004;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic        rready;
    logic [63:0] rdata;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
`ifdef CLINT_MTIMECMP_EN
    logic        mtip;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      ticks    = 0;
    longint      base_ticks = 0;
    logic [63:0] base     = '0;
    logic [63:0] cmp_model = '1;

    always #5 clock = ~clock;

    // mtime is a pure function of elapsed non-reset edges since the last reset or preload.
    always @(posedge clock) ticks <= reset ? 0 : ticks + 1;

    clint_axi_slave #(.DATA_W(64), .TICK_DIV(TICK_DIV), .READ_LAT(READ_LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arready(arready),
        .rready(rready), .rdata(rdata), .rvalid(rvalid), .rresp(rresp),
        .rid(rid), .rlast(rlast),
        .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bready(bready), .bvalid(bvalid), .bresp(bresp)
`ifdef CLINT_MTIMECMP_EN
        , .mtip(mtip)
`endif
    );

    function automatic logic [63:0] model_mtime();
        return base + 64'((ticks - base_ticks) / longint'(TICK_DIV));
    endfunction

    function automatic void exp_read(input logic [31:0] addr, input logic [63:0] snap,
                                     output logic [63:0] d, output logic [1:0] r);
        logic [31:0] w;
        bit hit;
        hit = 1;
        w   = '0;
        if (addr == A_TIME_L)      w = snap[31:0];
        else if (addr == A_TIME_H) w = snap[63:32];
`ifdef CLINT_MTIMECMP_EN
        else if (addr == A_CMP_L)  w = cmp_model[31:0];
        else if (addr == A_CMP_H)  w = cmp_model[63:32];
`endif
        else hit = 0;
        r = hit ? 2'b00 : 2'b11;
        d = !hit ? 64'h0 : (addr[2] ? {w, 32'h0} : {32'h0, w});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // stall: 0 = never, 1 = stall every beat, 2 = random
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int stall);
        logic [63:0] snap, ed;
        logic [1:0]  er;
        int n;
        n = 0;
        while (!arready && n < 50) begin @(negedge clock); n++; end
        chk("ar_ready", arready, 1);
        araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        snap = model_mtime();
        @(negedge clock);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clock); n++; end
        chk("r_latency", n, READ_LAT);
        if (len != 0) begin ed = '0; er = 2'b10; end
        else exp_read(addr, snap, ed, er);
        for (int b = 0; b <= int'(len); b++) begin
            chk("r_valid", rvalid, 1);
            chk("r_data", rdata, ed);
            chk("r_resp", rresp, er);
            chk("r_id", rid, id);
            chk("r_last", rlast, b == int'(len));
            if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge clock);
                chk("r_hold_valid", rvalid, 1);
                chk("r_hold_data", rdata, ed);
                chk("r_hold_resp", rresp, er);
                chk("r_hold_last", rlast, b == int'(len));
            end
            rready = 1;
            @(negedge clock);
            rready = 0;
        end
        chk("r_end_valid", rvalid, 0);
        chk("r_end_arready", arready, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int lp,
                            input logic [63:0] data, input logic [7:0] strb);
        logic [1:0] er;
        int n, nb, k;
        n = 0;
        while (!awready && n < 50) begin @(negedge clock); n++; end
        chk("aw_ready", awready, 1);
        awaddr = addr; awid = 4'($urandom); awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
        @(negedge clock);
        awvalid = 0;
        er = 2'b10;
`ifdef CLINT_MTIMECMP_EN
        if (len == 0 && (addr == A_CMP_L || addr == A_CMP_H)) begin
            er = 2'b00;
            for (int i = 0; i < 4; i++)
                if (strb[int'(addr[2])*4 + i])
                    cmp_model[int'(addr[2])*32 + i*8 +: 8] = data[int'(addr[2])*32 + i*8 +: 8];
        end
`endif
        nb = ((lp < int'(len)) ? lp : int'(len)) + 1;
        for (int b = 0; b < nb; b++) begin
            chk("w_ready", wready, 1);
            wdata  = (b == 0) ? data : {$urandom, $urandom};
            wstrb  = strb;
            wlast  = (b == lp);
            wvalid = 1;
            @(negedge clock);
        end
        wvalid = 0; wlast = 0;
        chk("w_end_ready", wready, 0);
        chk("b_valid", bvalid, 1);
        chk("b_resp", bresp, er);
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_resp", bresp, er);
        end
        bready = 1;
        @(negedge clock);
        bready = 0;
        chk("b_end_valid", bvalid, 0);
        chk("b_end_awready", awready, 1);
    endtask

    initial begin
        logic [31:0] atab [5];
        logic [63:0] tgt;
        int n;
        reset = 1; araddr = '0; arvalid = 0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 0; awaddr = '0; awvalid = 0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wdata = '0; wstrb = '0; wvalid = 0; wlast = 0; bready = 0;
        repeat (3) @(negedge clock);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
`ifdef CLINT_MTIMECMP_EN
        chk("rst_mtip", mtip, 0);
`endif
        reset = 0;
        @(negedge clock);
        chk("idle_arready", arready, 1);
        chk("idle_awready", awready, 1);
        chk("idle_rvalid", rvalid, 0);
        chk("idle_bvalid", bvalid, 0);

        n = 0;
        while (ticks < 10 && n < 50) begin @(negedge clock); n++; end
        do_read(A_TIME_L, 4'hA, 8'd0, 0);
        do_read(A_TIME_H, 4'h3, 8'd0, 0);
        do_read(A_TIME_L, 4'h6, 8'd3, 1);

        fork
            do_read(32'h8000_0000, 4'h5, 8'd0, 0);
            do_write(A_TIME_L, 8'd0, 0, 64'h0000_0000_DEAD_0000, 8'hFF);
        join
        do_read(A_TIME_L, 4'h1, 8'd0, 0);

        force dut.u_counter.mtime_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.u_counter.mtime_q;
        base = 64'hFFFF_FFFF_FFFF_FFFE;
        base_ticks = ticks;
        do_read(A_TIME_H, 4'h2, 8'd0, 0);
        do_read(A_TIME_H, 4'h2, 8'd0, 0);
        do_read(A_TIME_L, 4'h2, 8'd0, 2);

        atab[0] = A_TIME_L; atab[1] = A_TIME_H; atab[2] = A_CMP_L; atab[3] = A_CMP_H;
        for (int i = 0; i < 14; i++) begin
            atab[4] = {$urandom} & 32'hFFFF_FFF8;
            do_read(atab[$urandom_range(0, 4)], 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 4)) : 8'd0, 2);
        end
        for (int i = 0; i < 8; i++) begin
            atab[4] = {$urandom} & 32'hFFFF_FFF8;
            do_write(atab[$urandom_range(0, 4)], 8'($urandom_range(0, 2)), $urandom_range(0, 3),
                     {$urandom, $urandom}, 8'($urandom));
            do_read(atab[$urandom_range(0, 3)], 4'($urandom), 8'd0, 0);
        end

        // Abort a read while its beat is being presented.
        n = 0;
        while (!arready && n < 50) begin @(negedge clock); n++; end
        araddr = A_TIME_L; arid = 4'h9; arlen = 8'd1; arvalid = 1;
        @(negedge clock);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clock); n++; end
        chk("mid_rvalid", rvalid, 1);
        reset = 1;
        base = '0; base_ticks = 0; cmp_model = '1;
        #1;
        chk("mid_rst_arready", arready, 0);
        @(negedge clock);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready2", arready, 0);
        chk("mid_rst_awready", awready, 0);
        reset = 0;
        @(negedge clock);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_rvalid", rvalid, 0);
        do_read(A_TIME_L, 4'h4, 8'd0, 0);

`ifdef CLINT_MTIMECMP_EN
        do_read(A_CMP_H, 4'h7, 8'd0, 0);
        tgt = model_mtime() + 64'd40;
        do_write(A_CMP_L, 8'd0, 0, {32'hDEAD_BEEF, tgt[31:0]}, 8'h0F);
        do_write(A_CMP_H, 8'd0, 0, {32'h0, 32'h1234_5678}, 8'hF0);
        do_read(A_CMP_L, 4'h8, 8'd0, 0);
        n = 0;
        while (model_mtime() <= tgt + 64'd3 && n < 200) begin
            chk("mtip", mtip, model_mtime() > cmp_model);
            @(negedge clock);
            n++;
        end
        chk("mtip_final", mtip, 1);
`else
        do_read(A_CMP_L, 4'h7, 8'd0, 0);
        do_write(A_CMP_L, 8'd0, 0, 64'h20, 8'h0F);
        tgt = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
